mux_8to1_rr: RTL
================

# mux_8to1_rr

Eight-channel round-robin multiplexer with valid/ready handshakes and a registered output stage. It is the gathering end for the 1-to-8 demultiplexers. Eight producer channels compete for one output stream. Each delivered beat carries its 3-bit source index on `out_sel`, so a downstream `demux_1to8` can route it back by channel. Fairness comes from a rotating priority pointer, and throughput is one beat per clock.

## Interface
Parameters:
- `WIDTH`, default 8: data width per channel.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_data`, input, 8*WIDTH: channel i occupies `[i*WIDTH +: WIDTH]`.
- `in_valid`, input, 8: per-channel valid.
- `in_ready`, output, 8: per-channel ready; at most one bit is high per cycle.
- `out_data`, output, WIDTH: registered selected data.
- `out_sel`, output, 3: registered index of the source channel.
- `out_valid`, output, 1: output register holds a beat.
- `out_ready`, input, 1: downstream accepts the beat.

## Operation
- `load_en = !out_valid || out_ready`. The output register may load in a cycle where it is empty or is being drained.
- Arbitration is combinational:
  - Search `in_valid` starting at `ptr` and moving upward, modulo 8.
  - The first set bit is the grant `g`.
  - `in_ready[g] = load_en`. All other `in_ready` bits are 0.
  - With no `in_valid` set, all `in_ready` bits are 0.
- Transfer on channel g happens when `in_valid[g] && in_ready[g]`. On that edge:
  - `out_data <= in_data[g]`
  - `out_sel <= g`
  - `out_valid <= 1`
  - `ptr <= (g + 1) mod 8`; 7 wraps to 0.
- When `load_en` is high and no channel is valid: `out_valid <= 0`; `out_data`, `out_sel` and `ptr` hold.
- When `out_valid && !out_ready`: the output is stalled; `out_data`, `out_sel` and `ptr` hold and all `in_ready` bits are 0.
- A drain and a load in the same cycle is a back-to-back transfer with no bubble.
- The pointer advances only on an accepted beat, never on idle cycles.
- Reset values:
  - `out_valid = 0`, `out_data = 0`, `out_sel = 0`, `ptr = 0`, so channel 0 has first priority.
  - `in_ready = 0` while `rst_n` is low.
- Reset asserted mid-stream discards the held beat immediately; it is not delivered.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Sustained throughput is 1 beat per cycle while `out_ready` is high and any channel is valid.
- `in_ready` depends combinationally on `in_valid`, `ptr`, `out_valid` and `out_ready`.
- `out_*` are pure register outputs with no combinational path from the inputs.
- Fairness bound: with all 8 channels continuously valid and `out_ready` high, each channel is served exactly once every 8 cycles.

## Configuration
- `MUX_PKT_LOCK_EN` defined (packet lock):
  - Adds input `in_last [7:0]` and output `out_last` (1 bit, registered, reset 0).
  - Adds a two-state FSM:
    - IDLE: normal round-robin.
    - LOCKED: the grant is forced to `lock_ch`, even if other channels are valid.
  - IDLE to LOCKED on an accepted beat with `in_last[g] == 0`; `lock_ch <= g`.
  - LOCKED to IDLE on an accepted beat with `in_last[lock_ch] == 1`.
  - `ptr` updates only when a packet ends (last beat accepted).
  - While LOCKED, `in_valid[lock_ch] == 0` causes no grant; the packet is never interleaved.
  - Reset returns the FSM to IDLE.
- Macro undefined: no `in_last` or `out_last` ports, no FSM, and every beat is arbitrated independently.

## Structure
- Shared package `mux_pkg`:
  - `NUM_CH = 8`
  - `SEL_W = 3`
  - `typedef logic [SEL_W-1:0] sel_t`
  - Lock-state enum `lock_state_t {IDLE, LOCKED}`
- One sub-module, `rr_arbiter_8`: a combinational rotating-priority grant.
  - Inputs: `req[7:0]`, `ptr`.
  - Outputs: `gnt_onehot[7:0]`, `gnt_idx`, `gnt_any`.
- The top level holds the output register, `ptr` and the optional lock FSM.

## Test plan
- Reset: assert `rst_n = 0` mid-transfer.
  - Required: `out_valid = 0`, `out_sel = 0`, `in_ready = 0` immediately.
  - After release, the first grant goes to channel 0 when all channels are valid.
- Single channel: `in_valid = 8'b0010_0000`, `in_data[5] = 8'hA5`, `out_ready = 1`.
  - Required: one cycle later `out_data = 8'hA5`, `out_sel = 5`, `out_valid = 1`.
- All-valid rotation: `in_valid = 8'hFF`, `out_ready = 1` for 16 cycles.
  - Required: `out_sel` sequence 0,1,…,7,0,…,7 with no bubbles.
- Backpressure: `out_ready = 0` for 3 cycles while holding beat ch2 = 8'h3C.
  - Required: `out_*` stable and `in_ready = 0` throughout.
  - The next grant after release goes to ch3 if it is valid.
- Wrap and idle: last grant is ch7, then all channels idle for 2 cycles.
  - Required: `out_valid` falls after the drain and `ptr` stays at 0.
  - Then ch0 and ch6 both valid gives ch0 first.
- `MUX_PKT_LOCK_EN` only: ch1 sends a 3-beat packet (`in_last` on beat 3) while ch2 is continuously valid.
  - Required: `out_sel` = 1,1,1,2 and `out_last` is high only on the third beat.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and constants for the 8-to-1 round-robin multiplexer.
package mux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Channel that follows ch in rotation; 3-bit arithmetic wraps 7 to 0.
  function automatic sel_t next_ch(input sel_t ch);
    return ch + sel_t'(1);
  endfunction

endpackage

// File: rtl/mux_8to1_rr_arbiter.sv
// Combinational rotating-priority arbiter for 8 requesters.
// Searches req upward from ptr (modulo 8); the first set bit wins.
module rr_arbiter_8
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic [NUM_CH-1:0] gnt_onehot,
  output sel_t              gnt_idx,
  output logic              gnt_any
);

  sel_t idx;

  // Walk the eight channels in priority order and keep the first requester.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + sel_t'(k);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt_onehot = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;

endmodule

// File: rtl/mux_8to1_rr.sv
// Eight-channel round-robin multiplexer with valid/ready handshakes and a
// registered output stage. Each beat carries its source index on out_sel.
//
// Optional build macro: MUX_PKT_LOCK_EN adds in_last/out_last and a packet
// lock so a multi-beat packet is never interleaved with other channels.
//
// Lock FSM (MUX_PKT_LOCK_EN only):
//   state  | meaning
//   IDLE   | normal round-robin arbitration between all channels
//   LOCKED | mid-packet; only lock_ch may be granted until its last beat
module mux_8to1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
`ifdef MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  output logic [WIDTH-1:0]        out_data,
  output sel_t                    out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  sel_t              ptr;
  logic              load_en;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] gnt_onehot;
  sel_t              gnt_idx;
  logic              gnt_any;
  logic              xfer;
  logic              end_of_pkt;
  logic [WIDTH-1:0]  ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // The output register can take a new beat when empty or being drained.
  assign load_en = !out_valid || out_ready;

`ifdef MUX_PKT_LOCK_EN
  lock_state_t lock_state;
  sel_t        lock_ch;

  // While locked only the owning channel may request, so other valid
  // channels cannot slip a beat into the middle of a packet.
  assign req        = (lock_state == LOCKED) ? (in_valid & (NUM_CH'(1) << lock_ch))
                                             : in_valid;
  assign end_of_pkt = in_last[gnt_idx];
`else
  assign req        = in_valid;
  assign end_of_pkt = 1'b1;
`endif

  rr_arbiter_8 u_arb (
    .req        (req),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign xfer = gnt_any && load_en;

  // rst_n gates ready so no producer sees a handshake while reset is held.
  assign in_ready = (rst_n && load_en) ? gnt_onehot : '0;

  // Output register and rotating pointer; pointer moves only on packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[gnt_idx];
      out_sel   <= gnt_idx;
      if (end_of_pkt) begin
        ptr <= next_ch(gnt_idx);
      end
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  // Last-beat flag travels with the data in the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_last <= 1'b0;
    end else if (xfer) begin
      out_last <= in_last[gnt_idx];
    end else if (load_en) begin
      out_last <= 1'b0;
    end
  end

  // Packet lock FSM: enter on a non-last beat, leave on the owner's last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= IDLE;
      lock_ch    <= '0;
    end else if (xfer) begin
      case (lock_state)
        IDLE: begin
          if (!in_last[gnt_idx]) begin
            lock_state <= LOCKED;
            lock_ch    <= gnt_idx;
          end
        end
        LOCKED: begin
          if (in_last[lock_ch]) begin
            lock_state <= IDLE;
          end
        end
        default: lock_state <= IDLE;
      endcase
    end
  end
`endif

endmodule
